// File: rtl/bin_to_bcd_seq_if.sv
// Purpose: handshake/data bundle between a requester and bin_to_bcd_seq.
// Signals:
//   start  requester -> converter  request a conversion
//   bin    requester -> converter  unsigned binary operand, BIN_W bits
//   busy   converter -> requester  conversion in progress
//   done   converter -> requester  one-cycle pulse, bcd/ovf just updated
//   bcd    converter -> requester  packed BCD result, nibble k = 10^k digit
//   ovf    converter -> requester  last accepted operand was saturated
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output ovf
  );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Purpose: sequential binary-to-BCD converter (shift-and-add-3), one
//   iteration per clock, BIN_W iterations per conversion. Operands larger
//   than 10^DIGITS-1 saturate to all nines and raise ovf.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; aborts any conversion
//   bus   slave side of bin_to_bcd_seq_if (start/bin in, busy/done/bcd/ovf out)
//   BIN_W and DIGITS must match the parameters of the connected interface.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SCR_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [BCD_W-1:0] BCD_SAT  = {DIGITS{4'h9}};

  // Largest value representable in DIGITS decimal digits.
  function automatic longint unsigned max_repr();
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < int'(DIGITS); i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam longint unsigned MAX_VAL = max_repr();

  // False when every BIN_W-bit operand fits, making ovf a constant 0.
  function automatic bit ovf_possible();
    if (BIN_W >= 64) return 1'b1;
    return ((64'd1 << BIN_W) - 64'd1) > MAX_VAL;
  endfunction

  localparam bit OVF_POSSIBLE = ovf_possible();

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [SCR_W-1:0]   scr_q,      scr_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [BCD_W-1:0]   bcd_q,      bcd_d;
  logic               ovf_q,      ovf_d;

  logic [SCR_W-1:0]   scr_adj;
  logic [SCR_W-1:0]   scr_step;
  logic               ovf_next;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
  always_comb begin
    scr_adj = scr_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scr_adj[BIN_W + 4*k +: 4] >= 4'd5) begin
        scr_adj[BIN_W + 4*k +: 4] = scr_adj[BIN_W + 4*k +: 4] + 4'd3;
      end
    end
    scr_step = {scr_adj[SCR_W-2:0], 1'b0};
  end

  // Range check of the operand at capture time.
  always_comb begin
    ovf_next = OVF_POSSIBLE && (64'(bus.bin) > MAX_VAL);
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      // DONE accepts start exactly like IDLE so conversions can run back-to-back.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          scr_d      = {BCD_W'(0), bus.bin};
          cnt_d      = '0;
          ovf_pend_d = ovf_next;
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end else begin
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_SHIFT: begin
        scr_d = scr_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = ovf_pend_q ? BCD_SAT : scr_step[SCR_W-1:BIN_W];
          ovf_d   = ovf_pend_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Purpose: self-checking bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
//   A vector table and a few hand-written sequences drive conversions; each
//   accepted request pushes its expected result and accept cycle onto a
//   queue, and a monitor pops and compares whenever done pulses.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned NVEC   = 10;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int unsigned acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic done_prev = 1'b0;
  vec_t tbl [NVEC];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference: decimal digit extraction with saturation above 9999.
  function automatic logic [15:0] model_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    if (v > 9999) return 16'h9999;
    r = '0;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Scoreboard monitor: compare every done pulse against the oldest request.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      chk("done_one_cycle", 32'(done_prev), 0);
      chk("busy_low_at_done", 32'(bus.busy), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("bcd", 32'(bus.bcd), 32'(e.bcd));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        chk("latency", cyc - e.acc, BIN_W);
      end
    end
    done_prev <= bus.done;
  end

  // Request a conversion; caller is 1 ns past a rising edge with the DUT able to accept.
  task automatic issue(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    bus.bin   = v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{bcd: eb, ovf: eo, acc: cyc});
    bus.start = 1'b0;
    bus.bin   = 14'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [13:0] r;

    tbl[0] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
    tbl[1] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
    tbl[2] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
    tbl[3] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
    tbl[4] = '{bin: 14'd7,     bcd: 16'h0007, ovf: 1'b0};
    tbl[5] = '{bin: 14'd1,     bcd: 16'h0001, ovf: 1'b0};
    tbl[6] = '{bin: 14'd5005,  bcd: 16'h5005, ovf: 1'b0};
    tbl[7] = '{bin: 14'd8191,  bcd: 16'h8191, ovf: 1'b0};
    tbl[8] = '{bin: 14'd1000,  bcd: 16'h1000, ovf: 1'b0};
    tbl[9] = '{bin: 14'd10,    bcd: 16'h0010, ovf: 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_bcd",  32'(bus.bcd),  0);
    chk("rst_ovf",  32'(bus.ovf),  0);

    // Vector table, one isolated conversion each.
    for (int i = 0; i < int'(NVEC); i++) begin
      issue(tbl[i].bin, tbl[i].bcd, tbl[i].ovf);
      drain();
      @(posedge clk); #1;
    end

    // start and bin activity while busy must be ignored; outputs hold.
    issue(14'd9999, 16'h9999, 1'b0);
    drain();
    issue(14'd1234, 16'h1234, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.start = (i >= 2 && i <= 5);
      bus.bin   = 14'd5555;
      chk("hold_busy", 32'(bus.busy), 1);
      chk("hold_bcd",  32'(bus.bcd), 32'h9999);
    end
    bus.start = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back: new start during the done cycle.
    issue(14'd100, 16'h0100, 1'b0);
    for (int i = 0; i < 20 && !bus.done; i++) begin
      @(posedge clk); #1;
    end
    chk("b2b_done_seen", 32'(bus.done), 1);
    bus.bin   = 14'd42;
    bus.start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{bcd: 16'h0042, ovf: 1'b0, acc: cyc});
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 1);
    drain();
    @(posedge clk); #1;

    // Random operands against the reference.
    for (int i = 0; i < 8; i++) begin
      r = 14'($urandom_range(0, 16383));
      issue(r, model_bcd(int'(r)), r > 14'd9999);
      drain();
      @(posedge clk); #1;
    end

    // Reset on the 5th shift edge aborts with no done and clears outputs.
    issue(14'd12000, 16'h9999, 1'b1);
    drain();
    @(posedge clk); #1;
    issue(14'd77, 16'h0077, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_bcd",  32'(bus.bcd),  0);
    chk("abort_ovf",  32'(bus.ovf),  0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_bcd_later", 32'(bus.bcd), 0);
    issue(14'd808, 16'h0808, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
